// File: rtl/ascon_round_ctrl.sv
// ascon_round_ctrl
// Control FSM that sequences an Ascon permutation datapath through one
// authenticated encryption: initialisation, optional associated data,
// plaintext blocks, finalisation and tag.
//
// Optional feature macro: ASCON_AD_PHASE_EN
//   defined   -> one associated-data block is absorbed between INIT and the
//                plaintext phase (AD_WAIT / AD_RUN states present).
//   undefined -> the AD phase is skipped and its domain-separation bit is
//                folded into the XOR-down of the last INIT round.
//
// Ports
//   clock_i            single clock, rising edge
//   reset_i            synchronous active-high reset
//   start_i            begin an encryption (sampled only while idle)
//   key_i[127:0]       key, stable from start_i until done_o
//   data_i[63:0]       AD / PT block; data_valid_i / data_ready_o handshake
//   round_o[3:0]       permutation round index
//   input_select_o     load initial state (first INIT cycle)
//   ena_xor_up_o       XOR data_xor_up_o into the rate word
//   ena_xor_down_o     XOR data_xor_down_o into the state
//   ena_reg_state_o    state register update enable
//   data_xor_up_o      equals data_i
//   data_xor_down_o    XOR-down operand, zero when ena_xor_down_o=0
//   cipher_valid_o     ciphertext word valid on the datapath
//   tag_valid_o        tag valid on the datapath
//   busy_o / done_o    operation in progress / one-cycle completion pulse
module ascon_round_ctrl #(
  parameter int NUM_PT_BLOCKS = 4
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [63:0]  data_i,
  input  logic         data_valid_i,
  output logic         data_ready_o,
  output logic [3:0]   round_o,
  output logic         input_select_o,
  output logic         ena_xor_up_o,
  output logic         ena_xor_down_o,
  output logic         ena_reg_state_o,
  output logic [63:0]  data_xor_up_o,
  output logic [255:0] data_xor_down_o,
  output logic         cipher_valid_o,
  output logic         tag_valid_o,
  output logic         busy_o,
  output logic         done_o
);

`ifdef ASCON_AD_PHASE_EN
  typedef enum logic [2:0] {
    IDLE, INIT, AD_WAIT, AD_RUN, PT_WAIT, PT_RUN, FIN_RUN, TAG
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, INIT, PT_WAIT, PT_RUN, FIN_RUN, TAG
  } state_t;
`endif

  localparam logic [3:0] LAST_ROUND = 4'd11;
  localparam logic [3:0] MID_ROUND  = 4'd6;
  localparam logic [3:0] LAST_BLK   = 4'(NUM_PT_BLOCKS - 1);
  localparam logic       SINGLE_BLK = (NUM_PT_BLOCKS == 1);

  state_t     state_reg, state_next;
  logic [3:0] round_reg, round_next;
  logic [3:0] pt_cnt_reg, pt_cnt_next;

  logic [255:0] key_low;
  logic [255:0] key_mid;
  logic [255:0] init_xor;

  assign key_low = {128'b0, key_i};
  // Key injection ahead of the final plaintext block; needed by whichever
  // run precedes that block (AD, INIT or a plaintext run).
  assign key_mid = {64'b0, key_i, 64'b0};

`ifdef ASCON_AD_PHASE_EN
  assign init_xor = key_low;
`else
  // Without an AD phase the domain-separation bit (and, for one-block
  // messages, the pre-final key injection) lands on the last INIT round.
  assign init_xor = key_low ^ 256'd1 ^ (SINGLE_BLK ? key_mid : 256'd0);
`endif

  assign data_xor_up_o = data_i;

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_reg  <= IDLE;
      round_reg  <= 4'd0;
      pt_cnt_reg <= 4'd0;
    end else begin
      state_reg  <= state_next;
      round_reg  <= round_next;
      pt_cnt_reg <= pt_cnt_next;
    end
  end

  // Next-state logic. Handshake cycles in the wait states already act as
  // the first round of the following run, so the round counter jumps
  // straight to the second round of that run.
  always_comb begin
    state_next  = state_reg;
    round_next  = round_reg;
    pt_cnt_next = pt_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next  = INIT;
          round_next  = 4'd0;
          pt_cnt_next = 4'd0;
        end
      end
      INIT: begin
        if (round_reg == LAST_ROUND) begin
`ifdef ASCON_AD_PHASE_EN
          state_next = AD_WAIT;
`else
          state_next = PT_WAIT;
`endif
          round_next = 4'd0;
        end else begin
          round_next = round_reg + 4'd1;
        end
      end
`ifdef ASCON_AD_PHASE_EN
      AD_WAIT: begin
        if (data_valid_i) begin
          state_next = AD_RUN;
          round_next = MID_ROUND + 4'd1;
        end
      end
      AD_RUN: begin
        if (round_reg == LAST_ROUND) begin
          state_next = PT_WAIT;
          round_next = 4'd0;
        end else begin
          round_next = round_reg + 4'd1;
        end
      end
`endif
      PT_WAIT: begin
        if (data_valid_i) begin
          pt_cnt_next = pt_cnt_reg + 4'd1;
          if (pt_cnt_reg == LAST_BLK) begin
            state_next = FIN_RUN;
            round_next = 4'd1;
          end else begin
            state_next = PT_RUN;
            round_next = MID_ROUND + 4'd1;
          end
        end
      end
      PT_RUN: begin
        if (round_reg == LAST_ROUND) begin
          state_next = PT_WAIT;
          round_next = 4'd0;
        end else begin
          round_next = round_reg + 4'd1;
        end
      end
      FIN_RUN: begin
        if (round_reg == LAST_ROUND) begin
          state_next = TAG;
          round_next = 4'd0;
        end else begin
          round_next = round_reg + 4'd1;
        end
      end
      TAG: begin
        state_next = IDLE;
        round_next = 4'd0;
      end
      default: begin
        state_next  = IDLE;
        round_next  = 4'd0;
        pt_cnt_next = 4'd0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    data_ready_o    = 1'b0;
    round_o         = 4'd0;
    input_select_o  = 1'b0;
    ena_xor_up_o    = 1'b0;
    ena_xor_down_o  = 1'b0;
    ena_reg_state_o = 1'b0;
    data_xor_down_o = 256'd0;
    cipher_valid_o  = 1'b0;
    tag_valid_o     = 1'b0;
    busy_o          = 1'b1;
    done_o          = 1'b0;
    case (state_reg)
      IDLE: busy_o = 1'b0;
      INIT: begin
        ena_reg_state_o = 1'b1;
        round_o         = round_reg;
        input_select_o  = (round_reg == 4'd0);
        if (round_reg == LAST_ROUND) begin
          ena_xor_down_o  = 1'b1;
          data_xor_down_o = init_xor;
        end
      end
`ifdef ASCON_AD_PHASE_EN
      AD_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          ena_xor_up_o    = 1'b1;
          ena_reg_state_o = 1'b1;
          round_o         = MID_ROUND;
        end
      end
      AD_RUN: begin
        ena_reg_state_o = 1'b1;
        round_o         = round_reg;
        if (round_reg == LAST_ROUND) begin
          ena_xor_down_o  = 1'b1;
          data_xor_down_o = 256'd1 | (SINGLE_BLK ? key_mid : 256'd0);
        end
      end
`endif
      PT_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          ena_xor_up_o    = 1'b1;
          cipher_valid_o  = 1'b1;
          ena_reg_state_o = 1'b1;
          // The final block starts the 12-round finalisation directly.
          round_o         = (pt_cnt_reg == LAST_BLK) ? 4'd0 : MID_ROUND;
        end
      end
      PT_RUN: begin
        ena_reg_state_o = 1'b1;
        round_o         = round_reg;
        // Counter already points at the final block during the run before it.
        if (round_reg == LAST_ROUND && pt_cnt_reg == LAST_BLK) begin
          ena_xor_down_o  = 1'b1;
          data_xor_down_o = key_mid;
        end
      end
      FIN_RUN: begin
        ena_reg_state_o = 1'b1;
        round_o         = round_reg;
        if (round_reg == LAST_ROUND) begin
          ena_xor_down_o  = 1'b1;
          data_xor_down_o = key_low;
        end
      end
      TAG: begin
        tag_valid_o = 1'b1;
        done_o      = 1'b1;
      end
      default: busy_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ascon_round_ctrl.sv
module tb_ascon_round_ctrl;

  logic clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  logic         reset_i = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic [63:0]  data_i = '0;
  logic         data_valid_i = 1'b0;

`ifdef ASCON_AD_PHASE_EN
  localparam bit AD_EN = 1'b1;
`else
  localparam bit AD_EN = 1'b0;
`endif
  // Zero-wait latencies from start to done: 12 + 6(AD) + 6(N-1) + 12 + 1
  localparam int LAT4 = AD_EN ? 49 : 43;
  localparam int LAT1 = AD_EN ? 31 : 25;
  localparam logic [127:0] FIXED_KEY = 128'h000102030405060708090A0B0C0D0E0F;

  typedef struct packed {
    logic [3:0]   rnd;
    logic         isel;
    logic         xup;
    logic         xden;
    logic         rs;
    logic         rdy;
    logic         cv;
    logic         tv;
    logic         dn;
    logic         bsy;
    logic [255:0] xd;
  } ctl_t;

  typedef struct {
    bit   is_wait;
    ctl_t hs;  // expected outputs (handshake outputs for a wait entry)
    ctl_t wt;  // expected outputs while stalled
  } sched_t;

  typedef struct {
    int s; int n; int vpct; bit noise; int stall; bit abort; bit fixed_key;
    int lat; int exp_cv;
  } vec_t;

  // Two instances: four-block and one-block messages
  logic [3:0] round_a, round_b;
  logic isel_a, isel_b, xu_a, xu_b, xden_a, xden_b, rs_a, rs_b, rdy_a, rdy_b;
  logic cv_a, cv_b, tv_a, tv_b, dn_a, dn_b, bsy_a, bsy_b;
  logic [63:0]  xup_a, xup_b;
  logic [255:0] xd_a, xd_b;

  ascon_round_ctrl #(.NUM_PT_BLOCKS(4)) u_dut4 (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .key_i(key_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(rdy_a),
    .round_o(round_a), .input_select_o(isel_a), .ena_xor_up_o(xu_a),
    .ena_xor_down_o(xden_a), .ena_reg_state_o(rs_a), .data_xor_up_o(xup_a),
    .data_xor_down_o(xd_a), .cipher_valid_o(cv_a), .tag_valid_o(tv_a),
    .busy_o(bsy_a), .done_o(dn_a)
  );

  ascon_round_ctrl #(.NUM_PT_BLOCKS(1)) u_dut1 (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .key_i(key_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(rdy_b),
    .round_o(round_b), .input_select_o(isel_b), .ena_xor_up_o(xu_b),
    .ena_xor_down_o(xden_b), .ena_reg_state_o(rs_b), .data_xor_up_o(xup_b),
    .data_xor_down_o(xd_b), .cipher_valid_o(cv_b), .tag_valid_o(tv_b),
    .busy_o(bsy_b), .done_o(dn_b)
  );

  ctl_t obs_a, obs_b, obs;
  logic [63:0] xup;
  int sel = 0;
  assign obs_a = {round_a, isel_a, xu_a, xden_a, rs_a, rdy_a, cv_a, tv_a, dn_a, bsy_a, xd_a};
  assign obs_b = {round_b, isel_b, xu_b, xden_b, rs_b, rdy_b, cv_b, tv_b, dn_b, bsy_b, xd_b};
  always_comb begin
    obs = (sel == 1) ? obs_b : obs_a;
    xup = (sel == 1) ? xup_b : xup_a;
  end

  int errors = 0;
  int checks = 0;
  sched_t sched[$];

  task automatic chk_ctl(input string name, input int cyc, input ctl_t act, input ctl_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got rnd=%0d flags=%b xd=%h want rnd=%0d flags=%b xd=%h",
               name, cyc, act.rnd, act[264:256], act.xd, exp.rnd, exp[264:256], exp.xd);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  function automatic sched_t fx(input ctl_t c);
    sched_t e;
    e.is_wait = 1'b0; e.hs = c; e.wt = '0;
    return e;
  endfunction

  function automatic sched_t wx(input ctl_t h, input ctl_t w);
    sched_t e;
    e.is_wait = 1'b1; e.hs = h; e.wt = w;
    return e;
  endfunction

  // Expected cycle schedule of one message, derived from the protocol rules
  task automatic build(input int n, input logic [127:0] k);
    ctl_t c, wt;
    logic [255:0] kmid, klow;
    kmid = {64'b0, k, 64'b0};
    klow = {128'b0, k};
    sched.delete();
    for (int r = 0; r < 12; r++) begin
      c = '0; c.rnd = 4'(r); c.rs = 1'b1; c.bsy = 1'b1; c.isel = (r == 0);
      if (r == 11) begin
        c.xden = 1'b1; c.xd = klow;
        if (!AD_EN) begin
          c.xd ^= 256'd1;
          if (n == 1) c.xd ^= kmid;
        end
      end
      sched.push_back(fx(c));
    end
    wt = '0; wt.rdy = 1'b1; wt.bsy = 1'b1;
    if (AD_EN) begin
      c = wt; c.rnd = 4'd6; c.xup = 1'b1; c.rs = 1'b1;
      sched.push_back(wx(c, wt));
      for (int r = 7; r < 12; r++) begin
        c = '0; c.rnd = 4'(r); c.rs = 1'b1; c.bsy = 1'b1;
        if (r == 11) begin
          c.xden = 1'b1; c.xd = 256'd1 | ((n == 1) ? kmid : 256'd0);
        end
        sched.push_back(fx(c));
      end
    end
    for (int b = 0; b < n; b++) begin
      c = wt; c.xup = 1'b1; c.cv = 1'b1; c.rs = 1'b1;
      c.rnd = (b < n - 1) ? 4'd6 : 4'd0;
      sched.push_back(wx(c, wt));
      for (int r = (b < n - 1) ? 7 : 1; r < 12; r++) begin
        c = '0; c.rnd = 4'(r); c.rs = 1'b1; c.bsy = 1'b1;
        if (r == 11 && b == n - 2) begin c.xden = 1'b1; c.xd = kmid; end
        if (r == 11 && b == n - 1) begin c.xden = 1'b1; c.xd = klow; end
        sched.push_back(fx(c));
      end
    end
    c = '0; c.tv = 1'b1; c.dn = 1'b1; c.bsy = 1'b1;
    sched.push_back(fx(c));
  endtask

  // Reset held two edges with start/valid high: reset must win
  task automatic do_reset();
    @(negedge clock_i);
    reset_i = 1'b1; start_i = 1'b1; data_valid_i = 1'b1;
    @(negedge clock_i);
    #2 chk_ctl("reset_prio", 0, obs, '0);
    @(negedge clock_i);
    reset_i = 1'b0; start_i = 1'b0; data_valid_i = 1'b0;
  endtask

  task automatic run_case(input string name, input vec_t v);
    sched_t e;
    ctl_t   exp;
    int cyc, ncv, ntv, done_cyc, blk, stall_left, abort_cyc;
    bit hs;
    sel = v.s;
    key_i = v.fixed_key ? FIXED_KEY : {$urandom(), $urandom(), $urandom(), $urandom()};
    do_reset();
    build(v.n, key_i);
    @(negedge clock_i);
    start_i = 1'b1; data_valid_i = 1'b0; data_i = {$urandom(), $urandom()};
    #2 chk_ctl("idle_start", 0, obs, '0);
    cyc = 0; ncv = 0; ntv = 0; done_cyc = -1; blk = 0; stall_left = 0;
    abort_cyc = v.abort ? (12 + (AD_EN ? 6 : 0) + 6 * (v.n - 1) + 1 + 5) : -1;
    while (sched.size() > 0 && cyc < 400) begin
      @(negedge clock_i);
      cyc++;
      e = sched[0];
      start_i = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
      data_i = {$urandom(), $urandom()};
      if (e.is_wait && e.hs.cv && blk == v.stall && stall_left < 5) begin
        data_valid_i = 1'b0;
        stall_left++;
      end else if (e.is_wait) begin
        data_valid_i = ($urandom_range(1, 100) <= v.vpct);
      end else begin
        data_valid_i = 1'($urandom_range(0, 1));
      end
      reset_i = (cyc == abort_cyc);
      #2;
      hs = !e.is_wait || data_valid_i;
      exp = hs ? e.hs : e.wt;
      chk_ctl(name, cyc, obs, exp);
      checks++;
      if (xup !== data_i) begin
        errors++;
        $display("FAIL xor_up cyc=%0d got=%h want=%h", cyc, xup, data_i);
      end
      if (obs.cv) ncv++;
      if (obs.tv) ntv++;
      if (obs.dn) done_cyc = cyc;
      if (hs) begin
        if (e.is_wait && e.hs.cv) blk++;
        void'(sched.pop_front());
      end
      if (reset_i) break;
    end
    if (cyc >= 400) begin
      checks++; errors++;
      $display("FAIL %s timeout got=%0d cycles want<400", name, cyc);
    end
    @(negedge clock_i);
    reset_i = 1'b0; start_i = 1'b0; data_valid_i = 1'b0;
    #2 chk_ctl({name, "_after"}, cyc + 1, obs, '0);
    if (v.abort) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clock_i);
        #2 if (obs.tv) ntv++;
      end
      chk_int({name, "_no_tag"}, ntv, 0);
    end else begin
      chk_int({name, "_cipher_pulses"}, ncv, v.exp_cv);
      chk_int({name, "_tag_pulses"}, ntv, 1);
      if (v.lat > 0) chk_int({name, "_latency"}, done_cyc, v.lat);
    end
  endtask

  // Hand-written check of the INIT key injection against literal constants
  task automatic init_literal();
    logic [255:0] want;
    sel = 0;
    key_i = FIXED_KEY;
    do_reset();
    @(negedge clock_i);
    start_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock_i);
      start_i = 1'b0; data_valid_i = 1'b1;
    end
`ifdef ASCON_AD_PHASE_EN
    want = 256'h000102030405060708090A0B0C0D0E0F;
`else
    want = 256'h000102030405060708090A0B0C0D0E0E;
`endif
    #2 checks++;
    if (obs.xd !== want || obs.rnd !== 4'd11) begin
      errors++;
      $display("FAIL init_xd got rnd=%0d xd=%h want rnd=11 xd=%h", obs.rnd, obs.xd, want);
    end
`ifdef ASCON_AD_PHASE_EN
    for (int i = 0; i < 6; i++) @(negedge clock_i);
    #2 checks++;
    if (obs.xd !== 256'd1 || obs.rnd !== 4'd11) begin
      errors++;
      $display("FAIL ad_xd got rnd=%0d xd=%h want rnd=11 xd=1", obs.rnd, obs.xd);
    end
`endif
    data_valid_i = 1'b0;
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    // {dut, N, valid%, start noise, stall block, abort, fixed key, latency, cipher pulses}
    tbl[0] = '{0, 4, 100, 1'b0, -1, 1'b0, 1'b1, LAT4, 4};
    tbl[1] = '{1, 1, 100, 1'b0, -1, 1'b0, 1'b1, LAT1, 1};
    tbl[2] = '{0, 4, 100, 1'b1, -1, 1'b0, 1'b0, LAT4, 4};
    tbl[3] = '{0, 4, 100, 1'b0,  1, 1'b0, 1'b0, LAT4 + 5, 4};
    tbl[4] = '{0, 4, 100, 1'b1, -1, 1'b1, 1'b0, -1, 0};
    tbl[5] = '{0, 4,  60, 1'b1, -1, 1'b0, 1'b0, -1, 4};
    tbl[6] = '{1, 1,  50, 1'b0, -1, 1'b0, 1'b0, -1, 1};
    tbl[7] = '{1, 1, 100, 1'b0, -1, 1'b1, 1'b0, -1, 0};

    for (int i = 0; i < 8; i++) run_case($sformatf("vec%0d", i), tbl[i]);

    init_literal();

    for (int i = 0; i < 6; i++) begin
      rv = '{i % 2, (i % 2 == 1) ? 1 : 4, $urandom_range(40, 100), 1'($urandom_range(0, 1)),
             -1, 1'b0, 1'b0, -1, (i % 2 == 1) ? 1 : 4};
      run_case($sformatf("rand%0d", i), rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
